// File: rtl/instr_issue.sv
// instr_issue: queues instructions and issues them one at a time to an
// external combinational executor. Each issued instruction gets EXEC_LAT
// cycles to settle, then rd is captured and handed out with a
// valid/ready handshake.
// Optional feature macro: ISSUE_ACCUMULATE_EN. When defined, an internal
// accumulator is loaded with every captured result. Operand A of the next
// instruction comes from that accumulator instead of from in_a_i.
module instr_issue #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned EXEC_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [2:0] in_sel_i,
    input  logic [3:0] in_a_i,
    input  logic [3:0] in_b_i,
    output logic [3:0] rs_o,
    output logic [3:0] rt_o,
    output logic [2:0] sel_o,
    input  logic [3:0] rd_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [3:0] res_data_o,
    output logic       busy_o
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = AW + 1;

`ifdef ISSUE_ACCUMULATE_EN
    // Operand A is not queued; it comes from the accumulator at issue time.
    localparam int unsigned EntryW = 7;
    logic [3:0] unused_in_a;
    assign unused_in_a = in_a_i;
`else
    localparam int unsigned EntryW = 11;
`endif

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e              state_q, state_d;
    logic [EntryW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic [3:0]          rs_q, rs_d, rt_q, rt_d;
    logic [2:0]          sel_q, sel_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic                push, pop, full, empty;
    logic [EntryW-1:0]   wr_entry, head;
`ifdef ISSUE_ACCUMULATE_EN
    logic [3:0]          acc_q, acc_d;
`endif

    assign full       = (count_q == CntW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready_o = ~full;
    assign push       = in_valid_i & ~full;
    assign head       = mem_q[rd_ptr_q];

`ifdef ISSUE_ACCUMULATE_EN
    assign wr_entry = {in_sel_i, in_b_i};
`else
    assign wr_entry = {in_sel_i, in_a_i, in_b_i};
`endif

    // Queue storage; contents are only meaningful between wr and rd pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Queue pointers and occupancy; pointers wrap since depth is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    // Issue FSM: next state, operand loads, settle counter and result capture.
    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;
`ifdef ISSUE_ACCUMULATE_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop   = 1'b1;
`ifdef ISSUE_ACCUMULATE_EN
                    sel_d = head[6:4];
                    rs_d  = acc_q;
                    rt_d  = head[3:0];
`else
                    sel_d = head[10:8];
                    rs_d  = head[7:4];
                    rt_d  = head[3:0];
`endif
                    cnt_d   = 4'(EXEC_LAT);
                    state_d = StExec;
                end
            end
            StExec: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_data_d  = rd_i;
                    res_valid_d = 1'b1;
`ifdef ISSUE_ACCUMULATE_EN
                    acc_d       = rd_i;
`endif
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rs_q        <= '0;
            rt_q        <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef ISSUE_ACCUMULATE_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
`ifdef ISSUE_ACCUMULATE_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign sel_o       = sel_q;
    assign res_data_o  = res_data_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = (state_q != StIdle);

endmodule
